// File: rtl/lsu_unit_pkg.sv
// Shared types for the memory-stage load/store unit: funct3 size/sign codes
// and the access state enumeration.
package lsu_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_unit_if.sv
// Single-outstanding valid/grant data bus between the LSU (master) and memory (slave).
interface lsu_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_unit_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// extraction/extension and the misalignment flag for one funct3/offset pair.
module lsu_align
  import lsu_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  logic [31:0] shifted_s;

  // Size decode drives enables/replication/alignment; full funct3 drives extension.
  always_comb begin
    shifted_s   = rdata_i >> {addr_lo_i, 3'b000};
    be_o        = 4'b1111;
    wdata_rep_o = wdata_i;
    misalign_o  = 1'b0;
    ld_data_o   = rdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_rep_o = {2{wdata_i[15:0]}};
        misalign_o  = addr_lo_i[0];
      end
      default: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        misalign_o  = (addr_lo_i != 2'b00);
      end
    endcase
    case (funct3_i)
      F3_B:    ld_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   ld_data_o = {24'd0, shifted_s[7:0]};
      F3_H:    ld_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   ld_data_o = {16'd0, shifted_s[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Memory-stage load/store unit: issues one access at a time on the data bus
// and stalls the pipeline until the access completes, faults or times out.
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        stall_m,
  output logic        misalign,
  output logic        bus_err,
  lsu_unit_if.master  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic             bus_err_q, bus_err_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lo_q, lo_d;

  logic             op_s, idle_s, timeout_s, al_mis_s;
  logic [2:0]       al_f3_s;
  logic [1:0]       al_lo_s;
  logic [3:0]       al_be_s;
  logic [31:0]      al_wdata_s, al_ld_s;

  assign op_s      = mem_valid & (memread | memwrite);
  assign idle_s    = (state_q == IDLE);
  assign timeout_s = (cnt_q == TIMEOUT_C);

  // One lane unit: live inputs while issuing, captured size/offset while loading.
  assign al_f3_s = idle_s ? funct3 : f3_q;
  assign al_lo_s = idle_s ? addr[1:0] : lo_q;

  lsu_align u_align (
    .funct3_i    (al_f3_s),
    .addr_lo_i   (al_lo_s),
    .wdata_i     (wdata),
    .rdata_i     (bus.bus_rdata),
    .be_o        (al_be_s),
    .wdata_rep_o (al_wdata_s),
    .ld_data_o   (al_ld_s),
    .misalign_o  (al_mis_s)
  );

  assign misalign = op_s & al_mis_s & idle_s;
  assign stall_m  = op_s & ~al_mis_s & (state_q != DONE);

  // Next-state and bus/result register updates for the single outstanding access.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_data_d   = ld_data_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_s && !al_mis_s) begin
          bus_req_d   = 1'b1;
          bus_we_d    = memwrite;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = al_be_s;
          bus_wdata_d = al_wdata_s;
          f3_d        = funct3;
          lo_d        = addr[1:0];
          cnt_d       = {CNT_W{1'b0}};
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_s) begin
          bus_err_d = 1'b1;
          bus_req_d = 1'b0;
          ld_data_d = 32'd0;
          state_d   = DONE;
        end else if (bus.bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = bus_we_q ? DONE : WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_s) begin
          bus_err_d = 1'b1;
          ld_data_d = 32'd0;
          state_d   = DONE;
        end else if (bus.bus_rvalid) begin
          ld_data_d = al_ld_s;
          state_d   = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        ld_data_d = 32'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      ld_data_q   <= 32'd0;
      f3_q        <= 3'd0;
      lo_q        <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_err_q   <= bus_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_data_q   <= ld_data_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
    end
  end

  assign ld_data       = ld_data_q;
  assign bus_err       = bus_err_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed cases with literal expectations
// plus randomized traffic checked against a transaction-level model.
module tb_lsu_unit;
  import lsu_unit_pkg::*;

  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, ld_data;
  logic        stall_m, misalign, bus_err;

  lsu_unit_if bus_if ();

  lsu_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .memread   (memread),
    .memwrite  (memwrite),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .ld_data   (ld_data),
    .stall_m   (stall_m),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_mis, exp_err, exp_req, exp_we, chk_bus;
  logic [31:0] exp_ld, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: access size in bytes from funct3
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    int lo = int'(a % 4);
    return 4'(((1 << sz) - 1) << (lo - lo % sz));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    int sz = m_size(f3);
    if (sz == 1) return (wd % 256) * 32'h0101_0101;
    if (sz == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] w = rd >> (8 * (a % 4));
    int bv = int'(w % 256);
    int hv = int'(w % 65536);
    case (f3)
      F3_B:    return 32'(bv >= 128 ? bv - 256 : bv);
      F3_BU:   return 32'(bv);
      F3_H:    return 32'(hv >= 32768 ? hv - 65536 : hv);
      F3_HU:   return 32'(hv);
      default: return rd;
    endcase
  endfunction

  // Single compare process: DUT outputs against the model expectations.
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall_m",  32'(stall_m),          32'(exp_stall));
      chk("misalign", 32'(misalign),         32'(exp_mis));
      chk("bus_err",  32'(bus_err),          32'(exp_err));
      chk("bus_req",  32'(bus_if.bus_req),   32'(exp_req));
      chk("ld_data",  ld_data,               exp_ld);
      if (chk_bus) begin
        chk("bus_addr",  bus_if.bus_addr,      exp_addr);
        chk("bus_be",    32'(bus_if.bus_be),   32'(exp_be));
        chk("bus_wdata", bus_if.bus_wdata,     exp_wdata);
        chk("bus_we",    32'(bus_if.bus_we),   32'(exp_we));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    exp_stall = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_req = 1'b0;
    exp_ld = 32'd0; chk_bus = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // One instruction through the mem slot; gdly/rdly < 0 means the bus never responds.
  task automatic run_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int gdly, input int rdly,
                        input logic [31:0] rdata, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] eld);
    logic op_l, st_l, mis_l, err_l, gnt_l, got_l;
    int   t;
    op_l = v & (rd | wr); st_l = wr; mis_l = m_mis(f3, a);
    err_l = 1'b0; gnt_l = 1'b0; got_l = 1'b0; t = 0;
    mem_valid = v; memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    exp_stall = op_l & ~mis_l; exp_mis = op_l & mis_l; exp_err = 1'b0; exp_req = 1'b0;
    exp_ld = 32'd0; chk_bus = 1'b0;
    exp_addr = a & 32'hFFFF_FFFC; exp_be = ebe; exp_wdata = ewd; exp_we = st_l;
    step();
    if (op_l && !mis_l) begin
      for (int k = 0; k <= TIMEOUT && !gnt_l && !err_l; k++) begin
        exp_req = 1'b1; chk_bus = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0;
        bus_if.bus_rvalid = 1'($urandom_range(0, 1));
        bus_if.bus_rdata  = $urandom;
        if (t == TIMEOUT) begin
          err_l = 1'b1; bus_if.bus_gnt = 1'b0;
        end else begin
          gnt_l = (k == gdly); bus_if.bus_gnt = gnt_l;
        end
        step(); t++;
      end
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; exp_req = 1'b0; chk_bus = 1'b0;
      if (gnt_l && !st_l) begin
        for (int w = 0; w <= TIMEOUT && !got_l && !err_l; w++) begin
          if (t == TIMEOUT) err_l = 1'b1;
          else got_l = (w == rdly);
          bus_if.bus_rvalid = got_l;
          bus_if.bus_rdata  = got_l ? rdata : $urandom;
          step(); t++;
        end
        bus_if.bus_rvalid = 1'b0;
      end
      exp_stall = 1'b0; exp_err = err_l; exp_ld = (err_l || st_l) ? 32'd0 : eld;
      step();
      exp_err = 1'b0; exp_ld = 32'd0;
    end
  endtask

  logic [2:0] ld_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

  initial begin
    logic v, rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat;
    int kind;
    rst_n = 1'b0; mem_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;
    #3;
    chk("rst_bus_req",   32'(bus_if.bus_req), 32'd0);
    chk("rst_bus_we",    32'(bus_if.bus_we),  32'd0);
    chk("rst_bus_addr",  bus_if.bus_addr,     32'd0);
    chk("rst_bus_be",    32'(bus_if.bus_be),  32'd0);
    chk("rst_bus_wdata", bus_if.bus_wdata,    32'd0);
    chk("rst_ld_data",   ld_data,             32'd0);
    chk("rst_bus_err",   32'(bus_err),        32'd0);
    chk("rst_stall",     32'(stall_m),        32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    exp_valid = 1'b1;
    idle(2);

    run_op(1, 1, 0, F3_W,  32'h100, 32'h1234_5678, 2, 2, 32'hDEAD_BEEF, 4'b1111, 32'h1234_5678, 32'hDEAD_BEEF);
    run_op(1, 0, 1, F3_B,  32'h203, 32'h0000_00A5, 0, 0, 32'd0,        4'b1000, 32'hA5A5_A5A5, 32'd0);
    run_op(1, 1, 0, F3_B,  32'h11,  32'd0,         1, 1, 32'h0000_8000, 4'b0010, 32'd0,        32'hFFFF_FF80);
    run_op(1, 1, 0, F3_BU, 32'h11,  32'd0,         0, 0, 32'h0000_8000, 4'b0010, 32'd0,        32'h0000_0080);
    run_op(1, 1, 0, F3_HU, 32'h12,  32'd0,         3, 1, 32'hF00F_0000, 4'b1100, 32'd0,        32'h0000_F00F);
    run_op(1, 1, 0, F3_H,  32'h101, 32'd0,         0, 0, 32'd0,        4'b0000, 32'd0,        32'd0);
    run_op(1, 0, 1, F3_W,  32'h102, 32'd0,         0, 0, 32'd0,        4'b0000, 32'd0,        32'd0);
    idle(1);
    run_op(1, 1, 0, F3_W,  32'h400, 32'd0,        -1, 0, 32'd0,        4'b1111, 32'd0,        32'd0);
    run_op(1, 1, 0, F3_W,  32'h404, 32'd0,         1, -1, 32'd0,       4'b1111, 32'd0,        32'd0);
    run_op(1, 1, 0, F3_W,  32'h500, 32'd0,         1, 0, 32'hCAFE_F00D, 4'b1111, 32'd0,       32'hCAFE_F00D);
    run_op(1, 0, 1, F3_W,  32'h504, 32'h0BAD_CAFE, 0, 0, 32'd0,        4'b1111, 32'h0BAD_CAFE, 32'd0);
    run_op(1, 1, 1, F3_H,  32'h506, 32'h0000_1357, 1, 0, 32'd0,        4'b1100, 32'h1357_1357, 32'd0);
    idle(2);

    // Reset while a load waits for read data.
    exp_valid = 1'b0;
    mem_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = F3_W; addr = 32'h40;
    step();
    chk("pre_rst_req", 32'(bus_if.bus_req), 32'd1);
    bus_if.bus_gnt = 1'b1;
    step();
    bus_if.bus_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("midrst_ld_data", ld_data,             32'd0);
    mem_valid = 1'b0; memread = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    exp_valid = 1'b1;
    idle(1);
    run_op(1, 1, 0, F3_W, 32'h40, 32'd0, 1, 2, 32'h0102_0304, 4'b1111, 32'd0, 32'h0102_0304);

    for (int i = 0; i < 150; i++) begin
      v = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 3);
      rd = (kind == 0) || (kind == 2);
      wr = (kind == 1) || (kind == 2);
      f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a - (a % m_size(f3));
      wd = $urandom; rdat = $urandom;
      run_op(v, rd, wr, f3, a, wd, $urandom_range(0, 4), $urandom_range(0, 4), rdat,
             m_be(f3, a), m_wd(f3, wd), m_ld(f3, a, rdat));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit for the memory stage of the 5-stage core.
- Consumes the ex/mem pipeline register's memory controls, address and store data.
- Drives a single-outstanding valid/grant data-bus, returns aligned and extended load data toward the mem/wb register, and raises stall_m to the hazard unit while an access is in flight.
- Replaces a zero-latency data RAM so the core tolerates variable-latency memory.

Parameters:
- TIMEOUT, default 255: maximum cycles waiting in REQ or WAIT before the access is aborted with bus_err.
- CNT_W, default 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  mem-stage slot holds a valid instruction.
- memread  in  1  load instruction.
- memwrite  in  1  store instruction.
- funct3  in  3  access size and sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- ld_data  out  32  extended load result; valid in the DONE cycle.
- stall_m  out  1  hold fetch/decode/execute/mem; feeds the hazard unit.
- misalign  out  1  one-cycle pulse for a misaligned access; no bus access is made.
- bus_err  out  1  one-cycle pulse on timeout.
- bus_req  out  1  request valid.
- bus_we  out  1  write request.
- bus_addr  out  32  word address; bits [1:0] are forced to 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data word.

Behaviour:
- Reset: asynchronous, active-low on rst_n; synchronous to clk otherwise.
  - State goes to IDLE.
  - All registered outputs reset to 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, ld_data, misalign, bus_err, counter.
  - Reset mid-access drops bus_req immediately; the bus is expected to discard the outstanding transaction.
- op = mem_valid & (memread | memwrite). If both memread and memwrite are set, the access is treated as a store.
- Misalignment check:
  - Misaligned when a halfword access has addr[0]=1, or a word access has addr[1:0] != 0.
  - A misaligned op in IDLE: misalign=1 for that cycle (combinational), no state change, stall_m=0, ld_data=0.
- stall_m = op & ~misalign_now & (state != DONE). It is combinational so the first cycle of the op already stalls.
- States:
  - IDLE: on a valid aligned op, register bus_addr, bus_be, bus_wdata, bus_we and funct3, set bus_req=1, go to REQ.
  - REQ: bus_req, bus_addr, bus_be, bus_wdata and bus_we are held stable until bus_gnt. On bus_gnt, drop bus_req next cycle. Stores go to DONE; loads go to WAIT. bus_rvalid is ignored while in REQ.
  - WAIT: on bus_rvalid, ld_data <= extract(bus_rdata), go to DONE. Zero-latency read, where gnt and rvalid can coincide: not supported; rvalid must come at least one cycle after gnt.
  - DONE: stall_m is low for exactly one cycle so the pipeline advances; ld_data is held; next state is IDLE. The same instruction still occupies the mem slot in this cycle, and DONE must not reissue it.
- Timeout:
  - The counter clears on entering REQ and counts every cycle in REQ or WAIT.
  - When the count equals TIMEOUT: bus_err pulses, bus_req drops, ld_data <= 0, go to DONE.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
- Store data: bus_wdata replicates the byte (x4) or halfword (x2) across lanes.
- Load data:
  - Select the byte lane addr[1:0] or halfword lane addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.

Decomposition:
- Shared package (types.sv):
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - lsu_state_t enum {IDLE, REQ, WAIT, DONE}.
- Sub-module lsu_align: purely combinational.
  - Inputs: funct3 and addr[1:0].
  - Outputs: be, the replicated store data, extracted load data, and the misalign flag.
  - Instantiated once; the extraction path is reused on bus_rdata.

Test Plan:
- LW addr=0x100, gnt after 2 cycles, rvalid 3 cycles later with rdata 0xDEADBEEF:
  - bus_addr=0x100, be=1111.
  - ld_data=0xDEADBEEF in the DONE cycle.
  - stall_m high from op arrival until DONE.
- SB addr=0x203 wdata=0x000000A5, gnt same cycle as req:
  - be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200.
  - No WAIT state; DONE on the next cycle.
- LB addr=0x11 with rdata=0x0000_80_00 -> ld_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x12 with rdata=0xF00F_0000 -> 0x0000F00F.
- LH addr=0x101 -> misalign pulse for 1 cycle, bus_req never asserted, stall_m=0. SW addr=0x102 -> same response.
- Load with gnt never asserted -> bus_err at TIMEOUT cycles after entering REQ, ld_data=0, then IDLE. Back-to-back LW then SW -> each is issued once, with no duplicate req in DONE.
- rst_n low while in WAIT -> bus_req=0 and state IDLE immediately. After release, a new LW completes normally.
